mult_error_accum: RTL and testbench

Streaming error-statistics accumulator that sits directly downstream of the 16-bit multiplier under test. It consumes, per sample, the approximate product from the multiplier and the exact reference product for the same operands. It accumulates count, sum of absolute error distance (ED), maximum ED and number of erroneous samples over a run. The results feed the error-metric report (MED = sum/count computed in software).

---
 rtl/mult_error_accum.sv | 141 ++++++++++++++
 tb/tb_mult_error_accum.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_error_accum.sv
// Accumulates error-distance statistics between the approximate and exact multiplier products.
// Latency: a sample accepted at edge k reaches s1 at k, s2 at k+1 and the statistics at k+2.
// Backpressure: o_ready is high only in RUN; samples presented at any other time are dropped.
module mult_error_accum #(
  parameter int W     = 32,
  parameter int CNT_W = 16,
  parameter int ACC_W = 48
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic                i_valid,
  input  logic                i_last,
  input  logic signed [W-1:0] i_approx,
  input  logic signed [W-1:0] i_exact,
  output logic                o_ready,
  output logic                o_done,
  output logic [CNT_W-1:0]    o_count,
  output logic [CNT_W-1:0]    o_err_count,
  output logic [ACC_W-1:0]    o_sum_ed,
  output logic [W:0]          o_max_ed,
  output logic                o_overflow
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [W:0] ONE_ED = (W+1)'(1);

  state_t state, state_nxt;

  logic           accept;
  logic           clear;
  logic [W:0]     diff_c;
  logic [W:0]     s1_diff;
  logic           s1_vld;
  logic           s1_last;
  logic [W:0]     s1_neg;
  logic [W:0]     s2_ed;
  logic           s2_nz;
  logic           s2_vld;
  logic           s2_last;
  logic [ACC_W:0] sum_nxt;
  logic           cnt_full;
  logic           err_full;

  assign accept = i_valid && (state == RUN);
  // A start is only honoured from IDLE or DONE; it wins over a same-cycle sample.
  assign clear  = i_start && ((state == IDLE) || (state == DONE));

  // Sign-extend both products so the difference never truncates.
  assign diff_c = {i_approx[W-1], i_approx} - {i_exact[W-1], i_exact};
  assign s1_neg = ~s1_diff + ONE_ED;

  // Carry out of the widened add marks an accumulator overflow.
  assign sum_nxt  = {1'b0, o_sum_ed} + (ACC_W+1)'(s2_ed);
  assign cnt_full = &o_count;
  assign err_full = &o_err_count;

  assign o_ready = (state == RUN);
  assign o_done  = (state == DONE);

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic: DRAIN waits until the final sample leaves s2.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_start) state_nxt = RUN;
      RUN:     if (accept && i_last) state_nxt = DRAIN;
      DRAIN:   if (s2_vld && s2_last) state_nxt = DONE;
      DONE:    if (i_start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage 1: register the signed difference and sample flags.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_diff <= '0;
      s1_vld  <= 1'b0;
      s1_last <= 1'b0;
    end else begin
      s1_vld  <= accept;
      s1_last <= accept && i_last;
      if (accept) s1_diff <= diff_c;
    end
  end

  // Stage 2: absolute value (fits unsigned in W+1 bits) and nonzero flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s2_ed   <= '0;
      s2_nz   <= 1'b0;
      s2_vld  <= 1'b0;
      s2_last <= 1'b0;
    end else begin
      s2_vld  <= s1_vld;
      s2_last <= s1_last;
      if (s1_vld) begin
        s2_ed <= s1_diff[W] ? s1_neg : s1_diff;
        s2_nz <= (s1_diff != '0);
      end
    end
  end

  // Statistics: saturating counters/accumulator with a sticky overflow flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_count     <= '0;
      o_err_count <= '0;
      o_sum_ed    <= '0;
      o_max_ed    <= '0;
      o_overflow  <= 1'b0;
    end else if (clear) begin
      o_count     <= '0;
      o_err_count <= '0;
      o_sum_ed    <= '0;
      o_max_ed    <= '0;
      o_overflow  <= 1'b0;
    end else if (s2_vld) begin
      if (cnt_full) o_overflow <= 1'b1;
      else          o_count    <= o_count + CNT_W'(1);
      if (s2_nz) begin
        if (err_full) o_overflow  <= 1'b1;
        else          o_err_count <= o_err_count + CNT_W'(1);
      end
      if (sum_nxt[ACC_W]) begin
        o_sum_ed   <= '1;
        o_overflow <= 1'b1;
      end else begin
        o_sum_ed <= sum_nxt[ACC_W-1:0];
      end
      if (s2_ed > o_max_ed) o_max_ed <= s2_ed;
    end
  end

endmodule

// File: tb/tb_mult_error_accum.sv
// Scoreboard bench for mult_error_accum: a full-width instance and a CNT_W=4 instance share stimulus.
// Expected results are queued per run; monitors pop and compare on each rising o_done.
// Reset, restart-clear and mid-run reset states are checked directly.
module tb_mult_error_accum;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start, valid, last;
  logic signed [31:0] approx, exact;

  logic        a_ready, a_done, a_ovf;
  logic [15:0] a_count, a_err;
  logic [47:0] a_sum;
  logic [32:0] a_max;

  logic        b_ready, b_done, b_ovf;
  logic [3:0]  b_count, b_err;
  logic [47:0] b_sum;
  logic [32:0] b_max;

  typedef struct {
    logic [63:0] cnt;
    logic [63:0] err;
    logic [63:0] sum;
    logic [63:0] maxed;
    logic [63:0] ovf;
    logic [63:0] done_cyc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  logic a_prev = 1'b0;
  logic b_prev = 1'b0;

  mult_error_accum #(.W(32), .CNT_W(16), .ACC_W(48)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_valid(valid), .i_last(last),
    .i_approx(approx), .i_exact(exact), .o_ready(a_ready), .o_done(a_done),
    .o_count(a_count), .o_err_count(a_err), .o_sum_ed(a_sum), .o_max_ed(a_max),
    .o_overflow(a_ovf)
  );

  mult_error_accum #(.W(32), .CNT_W(4), .ACC_W(48)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_valid(valid), .i_last(last),
    .i_approx(approx), .i_exact(exact), .o_ready(b_ready), .o_done(b_done),
    .o_count(b_count), .o_err_count(b_err), .o_sum_ed(b_sum), .o_max_ed(b_max),
    .o_overflow(b_ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_res(input string tag, input exp_t e, input logic [63:0] c,
                         input logic [63:0] er, input logic [63:0] s,
                         input logic [63:0] m, input logic [63:0] o);
    chk({tag, "_count"},     c,   e.cnt);
    chk({tag, "_err_count"}, er,  e.err);
    chk({tag, "_sum_ed"},    s,   e.sum);
    chk({tag, "_max_ed"},    m,   e.maxed);
    chk({tag, "_overflow"},  o,   e.ovf);
    chk({tag, "_done_cyc"},  64'(cyc), e.done_cyc);
  endtask

  // Monitor for the full-width instance.
  always @(negedge clk) begin
    if (a_done && !a_prev) begin
      if (qa.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL a_unexpected_done: got done=1 expected no result pending");
      end else begin
        ea = qa.pop_front();
        cmp_res("a", ea, 64'(a_count), 64'(a_err), 64'(a_sum), 64'(a_max), 64'(a_ovf));
      end
    end
    a_prev <= a_done;
  end

  // Monitor for the narrow-counter instance.
  always @(negedge clk) begin
    if (b_done && !b_prev) begin
      if (qb.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL b_unexpected_done: got done=1 expected no result pending");
      end else begin
        eb = qb.pop_front();
        cmp_res("b", eb, 64'(b_count), 64'(b_err), 64'(b_sum), 64'(b_max), 64'(b_ovf));
      end
    end
    b_prev <= b_done;
  end

  task automatic expect_run(input logic [63:0] ca, input logic [63:0] era,
                            input logic [63:0] s, input logic [63:0] m, input logic [63:0] oa,
                            input logic [63:0] cb, input logic [63:0] erb, input logic [63:0] ob);
    exp_t e;
    e.sum = s; e.maxed = m; e.done_cyc = 64'(cyc + 2);
    e.cnt = ca; e.err = era; e.ovf = oa;
    qa.push_back(e);
    e.cnt = cb; e.err = erb; e.ovf = ob;
    qb.push_back(e);
  endtask

  task automatic stats_zero(input string tag);
    chk({tag, "_a_count"}, 64'(a_count), 0);
    chk({tag, "_a_err"},   64'(a_err),   0);
    chk({tag, "_a_sum"},   64'(a_sum),   0);
    chk({tag, "_a_max"},   64'(a_max),   0);
    chk({tag, "_a_ovf"},   64'(a_ovf),   0);
    chk({tag, "_b_count"}, 64'(b_count), 0);
    chk({tag, "_b_err"},   64'(b_err),   0);
    chk({tag, "_b_sum"},   64'(b_sum),   0);
    chk({tag, "_b_ovf"},   64'(b_ovf),   0);
  endtask

  task automatic check_idle(input string tag);
    stats_zero(tag);
    chk({tag, "_a_ready"}, 64'(a_ready), 0);
    chk({tag, "_a_done"},  64'(a_done),  0);
    chk({tag, "_b_ready"}, 64'(b_ready), 0);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic send(input logic signed [31:0] a, input logic signed [31:0] e, input logic l);
    valid = 1'b1; approx = a; exact = e; last = l;
    tick();
    valid = 1'b0; last = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int t = 0;
    while (!a_done && t < 20) begin tick(); t++; end
    n_cmp++;
    if (!a_done) begin
      n_fail++;
      $display("FAIL %s_timeout: got done=0 after %0d cycles expected done=1", tag, t);
    end
    @(negedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; valid = 1'b0; last = 1'b0; approx = '0; exact = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    check_idle("reset");

    // Samples offered in IDLE must be ignored.
    valid = 1'b1; approx = 32'sd50; exact = 32'sd0;
    repeat (5) tick();
    valid = 1'b0;
    check_idle("idle_valid");

    // Start with a same-cycle sample: sample dropped, run begins.
    start = 1'b1; valid = 1'b1; approx = 32'sd1000; exact = 32'sd0; last = 1'b1;
    tick();
    start = 1'b0; valid = 1'b0; last = 1'b0;
    chk("run_ready", 64'(a_ready), 1);
    send(32'sd100, 32'sd100, 1'b0);
    send(32'sd96,  32'sd100, 1'b0);
    send(32'sd110, 32'sd100, 1'b1);
    expect_run(3, 2, 14, 10, 0, 3, 2, 0);
    wait_done("basic");

    // Extreme operands: ED = 2^32 - 1.
    do_start();
    send(32'sh8000_0000, 32'sh7fff_ffff, 1'b1);
    expect_run(1, 1, 64'd4294967295, 64'd4294967295, 0, 1, 1, 0);
    wait_done("extreme");

    // Bubbles between samples, each ED = 1 (signs mixed).
    do_start();
    begin
      logic signed [31:0] ap[4];
      logic signed [31:0] ex[4];
      ap[0] = 32'sd5;  ex[0] = 32'sd4;
      ap[1] = -32'sd3; ex[1] = -32'sd2;
      ap[2] = 32'sd0;  ex[2] = 32'sd1;
      ap[3] = 32'sd7;  ex[3] = 32'sd6;
      for (int i = 0; i < 4; i++) begin
        repeat ($urandom_range(0, 3)) tick();
        send(ap[i], ex[i], i == 3);
      end
    end
    expect_run(4, 4, 4, 1, 0, 4, 4, 0);
    wait_done("bubbles");

    // 17 samples with ED = 1: narrow instance saturates at 15 and flags overflow.
    do_start();
    for (int i = 0; i < 17; i++) send(32'(i * 3 + 1), 32'(i * 3), i == 16);
    expect_run(17, 17, 17, 1, 0, 15, 15, 1);
    wait_done("saturate");
    do_start();
    stats_zero("restart");
    chk("restart_ready", 64'(a_ready), 1);
    send(32'sd20, 32'sd20, 1'b1);
    expect_run(1, 0, 0, 0, 0, 1, 0, 0);
    wait_done("zero_ed");

    // Reset pulse mid-run discards in-flight samples.
    do_start();
    send(32'sd1, 32'sd0, 1'b0);
    send(32'sd2, 32'sd0, 1'b0);
    rst_n = 1'b0;
    #2;
    check_idle("async_reset");
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check_idle("post_reset");
    do_start();
    send(32'sd10, 32'sd3, 1'b1);
    expect_run(1, 1, 7, 7, 0, 1, 1, 0);
    wait_done("after_reset");

    repeat (3) tick();
    chk("qa_empty", 64'(qa.size()), 0);
    chk("qb_empty", 64'(qb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
